// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32 control unit: FSM states, opcodes,
// ALU control codes and datapath select codes.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_HALT     = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_LWSW = 3'b010;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // Unknown opcodes (including X/Z) fall through to default and halt.
  function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] f3);
    state_t nxt;
    nxt = S_HALT;
    case (op)
      OP_LW, OP_SW: if (f3 == F3_LWSW) nxt = S_MEMADR;
      OP_RTYPE:     if (f3 == F3_ADD || f3 == F3_OR || f3 == F3_AND) nxt = S_EXECUTE;
      OP_ADDI:      if (f3 == F3_ADD) nxt = S_ADDI_EX;
      OP_BEQ:       if (f3 == F3_ADD) nxt = S_BRANCH;
      default:      nxt = S_HALT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/alu_control.sv
// ALU operation decode: fixed add/sub from the FSM, or funct3/funct7b5 for R-type.
module alu_control
  import multicycle_pkg::*;
(
  input  aluop_t      alu_op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  output logic [3:0]  ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          F3_ADD:  ALUControl = funct7b5 ? ALU_SUB : ALU_ADD;
          F3_AND:  ALUControl = ALU_AND;
          F3_OR:   ALUControl = ALU_OR;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32 main control: Moore FSM driving datapath selects and enables,
// sticky halt on illegal encodings, and a retired-instruction counter.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             PCSource,
  output logic [3:0]       ALUControl,
  output logic             halted,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_retired
);

  state_t           state_q, state_d;
  logic             halted_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  logic   pcw_uncond, branch, mem_read, mem_write, ir_write, reg_write;
  aluop_t alu_op;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE:   state_d = decode_next(opcode, funct3);
      S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTE,
      S_ADDI_EX:  state_d = S_RTYPE_WB;
      S_MEMWB,
      S_MEMWRITE,
      S_RTYPE_WB,
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_HALT;
    endcase
  end

  assign retire = (state_q == S_MEMWB)    || (state_q == S_MEMWRITE) ||
                  (state_q == S_RTYPE_WB) || (state_q == S_BRANCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_q | (state_d == S_HALT);
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    pcw_uncond = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    IorD       = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    PCSource   = 1'b0;
    alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        pcw_uncond = 1'b1;
      end
      S_DECODE:   ALUSrcB = SRCB_IMM;
      S_MEMADR,
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_IMM;
        IorD     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWRITE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        IorD      = 1'b1;
        mem_write = 1'b1;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        MemtoReg  = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
      end
      S_RTYPE_WB: reg_write = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        alu_op   = ALUOP_SUB;
        PCSource = 1'b1;
        branch   = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are masked by the async reset so no write escapes mid-instruction.
  assign PCWrite  = ~reset & (pcw_uncond | (branch & zero));
  assign MemRead  = ~reset & mem_read;
  assign MemWrite = ~reset & mem_write;
  assign IRWrite  = ~reset & ir_write;
  assign RegWrite = ~reset & reg_write;

  alu_control u_alu_control (
    .alu_op     (alu_op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .ALUControl (ALUControl)
  );

  assign halted        = halted_q;
  assign state         = state_q;
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: drives a small behavioural multicycle datapath
// and scoreboards per-cycle control outputs plus final architectural state.
module tb_multicycle_control;
  import multicycle_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5, zero;
  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite;
  logic        ALUSrcA, PCSource, halted;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUControl, state;
  logic [31:0] instr_retired;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .PCWrite(PCWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUControl(ALUControl),
    .halted(halted), .state(state), .instr_retired(instr_retired)
  );

  // Behavioural datapath; memory is word-per-address, indexed by byte address.
  logic [31:0] mem [256];
  logic [31:0] img [256];
  logic [31:0] rf [32];
  logic [31:0] rf_img [32];
  logic        fetched [256];
  logic [31:0] pc, ir, a_q, b_q, aluout, mdr, pc_init;
  logic [31:0] imm, srca, srcb, alures, maddr, mdata;
  logic        load = 1'b0;

  assign opcode   = ir[6:0];
  assign funct3   = ir[14:12];
  assign funct7b5 = ir[30];
  assign zero     = (alures == 32'd0);

  always_comb begin
    case (ir[6:0])
      7'b0100011: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      7'b1100011: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default:    imm = {{20{ir[31]}}, ir[31:20]};
    endcase
    srca = ALUSrcA ? a_q : pc;
    case (ALUSrcB)
      2'b00:   srcb = b_q;
      2'b01:   srcb = 32'd4;
      2'b10:   srcb = imm;
      default: srcb = 32'hBAD0_BAD0;
    endcase
    case (ALUControl)
      4'b0000: alures = srca & srcb;
      4'b0001: alures = srca | srcb;
      4'b0010: alures = srca + srcb;
      4'b0110: alures = srca - srcb;
      default: alures = 32'hDEAD_BEEF;
    endcase
    maddr = IorD ? aluout : pc;
    mdata = mem[maddr[7:0]];
  end

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) begin
        mem[i]     <= img[i];
        fetched[i] <= 1'b0;
      end
      for (int i = 0; i < 32; i++) rf[i] <= rf_img[i];
    end else begin
      if (MemWrite) mem[maddr[7:0]] <= b_q;
      if (IRWrite) begin
        ir <= mdata;
        fetched[maddr[7:0]] <= 1'b1;
      end
      if (RegWrite && ir[11:7] != 5'd0) rf[ir[11:7]] <= MemtoReg ? mdr : aluout;
    end
    if (reset) begin
      pc <= pc_init; ir <= '0; a_q <= '0; b_q <= '0; aluout <= '0; mdr <= '0;
    end else begin
      if (PCWrite) pc <= PCSource ? aluout : alures;
      a_q    <= rf[ir[19:15]];
      b_q    <= rf[ir[24:20]];
      aluout <= alures;
      mdr    <= mdata;
    end
  end

  typedef struct {
    logic [3:0]  st;
    logic [4:0]  en;
    logic [3:0]  alu;
    logic [31:0] ret;
    logic        hlt;
  } exp_t;

  typedef enum {K_LW, K_SW, K_R, K_I, K_BEQ} kind_t;

  exp_t        sb_q [$];
  logic [31:0] exp_ret;
  logic        exp_hlt;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Enable vector order: {PCWrite, MemRead, MemWrite, IRWrite, RegWrite}.
  function automatic logic [4:0] exp_en(input logic [3:0] st, input logic take);
    case (st)
      4'd0:    return 5'b11010;
      4'd3:    return 5'b01000;
      4'd4:    return 5'b00001;
      4'd5:    return 5'b00100;
      4'd7:    return 5'b00001;
      4'd8:    return {take, 4'b0000};
      default: return 5'b00000;
    endcase
  endfunction

  task automatic push_cyc(input logic [3:0] st, input logic take, input logic [3:0] alu,
                          input logic retire);
    exp_t e;
    e.st = st; e.en = exp_en(st, take); e.alu = alu; e.ret = exp_ret; e.hlt = exp_hlt;
    sb_q.push_back(e);
    if (retire) exp_ret++;
  endtask

  task automatic push_instr(input kind_t k, input logic [3:0] exalu, input logic take);
    push_cyc(4'd0, 1'b0, ALU_ADD, 1'b0);
    push_cyc(4'd1, 1'b0, ALU_ADD, 1'b0);
    case (k)
      K_LW: begin
        push_cyc(4'd2, 1'b0, ALU_ADD, 1'b0);
        push_cyc(4'd3, 1'b0, ALU_ADD, 1'b0);
        push_cyc(4'd4, 1'b0, ALU_ADD, 1'b1);
      end
      K_SW: begin
        push_cyc(4'd2, 1'b0, ALU_ADD, 1'b0);
        push_cyc(4'd5, 1'b0, ALU_ADD, 1'b1);
      end
      K_R: begin
        push_cyc(4'd6, 1'b0, exalu, 1'b0);
        push_cyc(4'd7, 1'b0, ALU_ADD, 1'b1);
      end
      K_I: begin
        push_cyc(4'd9, 1'b0, ALU_ADD, 1'b0);
        push_cyc(4'd7, 1'b0, ALU_ADD, 1'b1);
      end
      default: push_cyc(4'd8, take, ALU_SUB, 1'b1);
    endcase
  endtask

  task automatic push_illegal(input int n);
    push_cyc(4'd0, 1'b0, ALU_ADD, 1'b0);
    push_cyc(4'd1, 1'b0, ALU_ADD, 1'b0);
    exp_hlt = 1'b1;
    for (int i = 0; i < n; i++) push_cyc(4'd10, 1'b0, ALU_ADD, 1'b0);
  endtask

  task automatic run_sb();
    exp_t e;
    while (sb_q.size() > 0) begin
      #1;
      e = sb_q.pop_front();
      check_eq($sformatf("state@%0d", cyc), state, e.st);
      check_eq($sformatf("enables@%0d", cyc),
               {PCWrite, MemRead, MemWrite, IRWrite, RegWrite}, e.en);
      check_eq($sformatf("alu@%0d", cyc), ALUControl, e.alu);
      check_eq($sformatf("retired@%0d", cyc), instr_retired, e.ret);
      check_eq($sformatf("halted@%0d", cyc), halted, e.hlt);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = '0;
    for (int i = 0; i < 32; i++) rf_img[i] = '0;
  endtask

  task automatic start(input logic [31:0] pc0);
    pc_init = pc0;
    reset = 1'b1;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    #1;
    check_eq("rst_state", state, 32'd0);
    check_eq("rst_enables", {PCWrite, MemRead, MemWrite, IRWrite, RegWrite}, 32'd0);
    check_eq("rst_halted", halted, 32'd0);
    check_eq("rst_retired", instr_retired, 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    exp_ret = '0;
    exp_hlt = 1'b0;
    cyc     = 0;
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm12, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm12, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic f7b5, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, OP_RTYPE};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm12, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm12[11:5], rs2, rs1, F3_LWSW, imm12[4:0], OP_SW};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm13, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm13[12], imm13[10:5], rs2, rs1, 3'b000, imm13[4:1], imm13[11], OP_BEQ};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Main 8-instruction program; beq at 16 skips 20/24, opcode 0 at 40 halts.
    clear_img();
    img[0]  = enc_i(12'd20, 5'd0, 3'b000, 5'd3, OP_ADDI);
    img[4]  = enc_s(12'd150, 5'd3, 5'd0);
    img[8]  = enc_i(12'd150, 5'd0, 3'b010, 5'd11, OP_LW);
    img[12] = enc_i(12'd16, 5'd0, 3'b000, 5'd13, OP_ADDI);
    img[16] = enc_b(13'd8, 5'd11, 5'd3);
    img[20] = enc_i(12'd99, 5'd0, 3'b000, 5'd3, OP_ADDI);
    img[24] = enc_i(12'd99, 5'd0, 3'b000, 5'd8, OP_ADDI);
    img[28] = enc_i(12'd82, 5'd0, 3'b000, 5'd8, OP_ADDI);
    img[32] = enc_r(1'b0, 5'd3, 5'd8, 3'b000, 5'd10);
    img[36] = enc_r(1'b1, 5'd13, 5'd10, 3'b000, 5'd14);
    start(32'd0);
    push_instr(K_I, ALU_ADD, 1'b0);
    push_instr(K_SW, ALU_ADD, 1'b0);
    push_instr(K_LW, ALU_ADD, 1'b0);
    push_instr(K_I, ALU_ADD, 1'b0);
    push_instr(K_BEQ, ALU_ADD, 1'b1);
    push_instr(K_I, ALU_ADD, 1'b0);
    push_instr(K_R, ALU_ADD, 1'b0);
    push_instr(K_R, ALU_SUB, 1'b0);
    push_illegal(5);
    run_sb();
    check_eq("x3", rf[3], 32'd20);
    check_eq("x8", rf[8], 32'd82);
    check_eq("x10", rf[10], 32'd102);
    check_eq("x11", rf[11], 32'd20);
    check_eq("x13", rf[13], 32'd16);
    check_eq("x14", rf[14], 32'd86);
    check_eq("mem150", mem[150], 32'd20);
    check_eq("fetched20", fetched[20], 32'd0);
    check_eq("fetched24", fetched[24], 32'd0);
    check_eq("fetched28", fetched[28], 32'd1);

    // beq not taken
    clear_img();
    rf_img[3]  = 32'd20;
    rf_img[11] = 32'd21;
    img[16]    = enc_b(13'd8, 5'd11, 5'd3);
    start(32'd16);
    push_instr(K_BEQ, ALU_ADD, 1'b0);
    run_sb();
    check_eq("beq_nt_pc", pc, 32'd20);
    check_eq("beq_nt_retired", instr_retired, 32'd1);

    // Async reset pulse while in MEMWRITE
    clear_img();
    rf_img[3] = 32'd20;
    img[150]  = 32'd77;
    img[0]    = enc_i(12'd1, 5'd0, 3'b000, 5'd5, OP_ADDI);
    img[4]    = enc_s(12'd150, 5'd3, 5'd0);
    start(32'd0);
    push_instr(K_I, ALU_ADD, 1'b0);
    push_cyc(4'd0, 1'b0, ALU_ADD, 1'b0);
    push_cyc(4'd1, 1'b0, ALU_ADD, 1'b0);
    push_cyc(4'd2, 1'b0, ALU_ADD, 1'b0);
    run_sb();
    #1;
    check_eq("memwr_state", state, 32'd5);
    check_eq("memwr_en", MemWrite, 32'd1);
    check_eq("memwr_retired", instr_retired, 32'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("arst_memwrite", MemWrite, 32'd0);
    check_eq("arst_state", state, 32'd0);
    check_eq("arst_retired", instr_retired, 32'd0);
    @(negedge clk);
    #1;
    check_eq("arst_mem150", mem[150], 32'd77);

    // addi with imm bit 10 set, and/or, then illegal R-type funct3=001
    clear_img();
    rf_img[3]  = 32'd20;
    rf_img[11] = 32'd21;
    img[0]  = enc_i(12'h405, 5'd3, 3'b000, 5'd6, OP_ADDI);
    img[4]  = enc_r(1'b0, 5'd11, 5'd3, 3'b111, 5'd7);
    img[8]  = enc_r(1'b0, 5'd11, 5'd3, 3'b110, 5'd9);
    img[12] = enc_r(1'b0, 5'd11, 5'd3, 3'b001, 5'd12);
    start(32'd0);
    push_instr(K_I, ALU_ADD, 1'b0);
    push_instr(K_R, ALU_AND, 1'b0);
    push_instr(K_R, ALU_OR, 1'b0);
    push_illegal(3);
    run_sb();
    check_eq("addi_f7b5_x6", rf[6], 32'd1049);
    check_eq("and_x7", rf[7], 32'd20);
    check_eq("or_x9", rf[9], 32'd21);
    check_eq("illegal_x12", rf[12], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
